// File: rtl/sevenseg_scan_ctrl_if.sv
// Character stream from the text generator into the scan/scroll controller.
// The generator drives the master side and the controller takes the slave side.
interface sevenseg_scan_ctrl_if;
    logic [3:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_in,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output char_ready
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit seven-segment scan controller with dead-time blanking and a
// character scroll buffer fed from the text generator.
module sevenseg_scan_ctrl #(
    parameter int unsigned DIGIT_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES  = 1000,
    parameter int unsigned SCROLL_FRAMES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    sevenseg_scan_ctrl_if.slave        chars,
    output logic [3:0]                 an,
    output logic [3:0]                 digit,
    output logic [1:0]                 digit_sel,
    output logic                       frame_tick
);

    localparam logic [15:0] BLANK_LAST  = 16'(BLANK_CYCLES - 1);
    localparam logic [15:0] DIGIT_LAST  = 16'(DIGIT_CYCLES - 1);
    localparam logic [15:0] SCROLL_LAST = 16'(SCROLL_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_BLANK   = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_ADVANCE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [15:0]     cycle_cnt;
    logic [15:0]     cycle_cnt_next;
    logic [15:0]     frame_cnt;
    logic            scroll_pending;
    logic [3:0][3:0] scroll_buf;

    logic            frame_end;
    logic            scroll_point;
    logic            transfer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_BLANK;
            cycle_cnt <= '0;
        end else begin
            state     <= state_next;
            cycle_cnt <= cycle_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        cycle_cnt_next = cycle_cnt + 16'd1;
        unique case (state)
            ST_BLANK: begin
                if (cycle_cnt == BLANK_LAST) begin
                    state_next     = ST_DRIVE;
                    cycle_cnt_next = '0;
                end
            end
            ST_DRIVE: begin
                if (cycle_cnt == DIGIT_LAST) begin
                    state_next     = ST_ADVANCE;
                    cycle_cnt_next = '0;
                end
            end
            ST_ADVANCE: begin
                state_next     = ST_BLANK;
                cycle_cnt_next = '0;
            end
            default: begin
                state_next     = ST_BLANK;
                cycle_cnt_next = '0;
            end
        endcase
    end

    // Anodes are only lit in DRIVE, so BLANK and ADVANCE both act as dead time.
    always_comb begin
        an = 4'b1111;
        if (state == ST_DRIVE) begin
            an = ~(4'b0001 << digit_sel);
        end
    end

    assign frame_end        = (state == ST_ADVANCE) && (digit_sel == 2'd3);
    assign scroll_point     = frame_end && enable && (frame_cnt == SCROLL_LAST);
    assign chars.char_ready = scroll_pending && (state == ST_BLANK);
    assign transfer         = chars.char_valid && chars.char_ready;

    // The next digit's character is latched as BLANK is entered, so a shift
    // later in that BLANK window only shows up on the following visit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_sel <= 2'd0;
            digit     <= 4'd0;
        end else if (state == ST_ADVANCE) begin
            digit_sel <= digit_sel + 2'd1;
            digit     <= scroll_buf[digit_sel + 2'd1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_tick <= frame_end;
            if (frame_end && enable) begin
                frame_cnt <= (frame_cnt == SCROLL_LAST) ? 16'd0 : frame_cnt + 16'd1;
            end
        end
    end

    // A scroll point reached while still pending leaves the flag set; it
    // never queues a second shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scroll_pending <= 1'b0;
        end else if (scroll_point) begin
            scroll_pending <= 1'b1;
        end else if (transfer) begin
            scroll_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scroll_buf <= '0;
        end else if (transfer) begin
            scroll_buf <= {scroll_buf[2:0], chars.char_in};
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: a phase table of scripted scroll scenarios,
// a mid-scan reset sequence and random traffic, all against a timeline model.
module tb_sevenseg_scan_ctrl;

    localparam int DC = 4;
    localparam int BC = 2;
    localparam int SF = 2;
    localparam int DP = BC + DC + 1;
    localparam int FP = 4 * DP;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] an;
    logic [3:0] digit;
    logic [1:0] digit_sel;
    logic       frame_tick;

    sevenseg_scan_ctrl_if chars();

    sevenseg_scan_ctrl #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC),
        .SCROLL_FRAMES(SF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .chars     (chars),
        .an        (an),
        .digit     (digit),
        .digit_sel (digit_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        bit         valid;
        logic [3:0] ch;
        int         cycles;
        int         exp_xfers;
    } phase_t;

    phase_t tbl [12];

    int         vectors     = 0;
    int         miscompares = 0;
    int         dut_xfers   = 0;

    // Model: k counts clocks since reset release; everything about the scan
    // follows from k, and the buffer is a plain array of characters.
    int         k;
    logic [3:0] mbuf [4];
    bit         mpend;
    int         mfcnt;
    logic [3:0] mdigit;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            if (miscompares <= 25)
                $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
                         name, k, actual, expected);
        end
    endtask

    function automatic void modelReset();
        k      = 0;
        mpend  = 1'b0;
        mfcnt  = 0;
        mdigit = 4'd0;
        for (int i = 0; i < 4; i++) mbuf[i] = 4'd0;
    endfunction

    task automatic checkCycle();
        int         p;
        int         d;
        logic [3:0] one_hot;
        logic [3:0] exp_an;
        p       = k % DP;
        d       = (k / DP) % 4;
        one_hot = 4'b0001 << d;
        exp_an  = (p >= BC && p < BC + DC) ? ~one_hot : 4'b1111;
        checkOutput("an",         16'(an),              16'(exp_an));
        checkOutput("digit_sel",  16'(digit_sel),       16'(d));
        checkOutput("digit",      16'(digit),           16'(mdigit));
        checkOutput("frame_tick", 16'(frame_tick),      16'((k > 0) && (k % FP == 0)));
        checkOutput("char_ready", 16'(chars.char_ready), 16'(mpend && (p < BC)));
    endtask

    task automatic applyStimulus(input bit en, input bit v, input logic [3:0] ch);
        bit xfer;
        enable           = en;
        chars.char_valid = v;
        chars.char_in    = ch;
        #1;
        if (chars.char_ready && v) dut_xfers++;
        xfer = mpend && (k % DP < BC) && v;
        @(posedge clk);
        if (xfer) begin
            mbuf[3] = mbuf[2];
            mbuf[2] = mbuf[1];
            mbuf[1] = mbuf[0];
            mbuf[0] = ch;
            mpend   = 1'b0;
        end
        if ((k % FP == FP - 1) && en) begin
            if (mfcnt == SF - 1) begin
                mfcnt = 0;
                mpend = 1'b1;
            end else begin
                mfcnt++;
            end
        end
        k++;
        if (k % DP == 0) mdigit = mbuf[(k / DP) % 4];
        #1;
        checkCycle();
    endtask

    initial begin
        tbl[0]  = '{en: 1, valid: 0, ch: 4'h0, cycles: 56,  exp_xfers: 0};
        tbl[1]  = '{en: 1, valid: 1, ch: 4'h1, cycles: 56,  exp_xfers: 1};
        tbl[2]  = '{en: 1, valid: 1, ch: 4'h2, cycles: 56,  exp_xfers: 1};
        tbl[3]  = '{en: 1, valid: 1, ch: 4'h3, cycles: 56,  exp_xfers: 1};
        tbl[4]  = '{en: 1, valid: 1, ch: 4'h4, cycles: 56,  exp_xfers: 1};
        tbl[5]  = '{en: 1, valid: 0, ch: 4'h9, cycles: 56,  exp_xfers: 0};
        tbl[6]  = '{en: 1, valid: 1, ch: 4'h5, cycles: 27,  exp_xfers: 1};
        tbl[7]  = '{en: 0, valid: 1, ch: 4'h6, cycles: 168, exp_xfers: 0};
        tbl[8]  = '{en: 1, valid: 0, ch: 4'h7, cycles: 57,  exp_xfers: 0};
        tbl[9]  = '{en: 1, valid: 1, ch: 4'hF, cycles: 28,  exp_xfers: 1};
        tbl[10] = '{en: 1, valid: 1, ch: 4'h0, cycles: 28,  exp_xfers: 1};
        tbl[11] = '{en: 1, valid: 0, ch: 4'hA, cycles: 56,  exp_xfers: 0};

        reset            = 1'b1;
        enable           = 1'b0;
        chars.char_valid = 1'b0;
        chars.char_in    = 4'd0;
        modelReset();
        #1 reset = 1'b0;
        #11;
        checkOutput("reset_an",         16'(an),               16'hF);
        checkOutput("reset_digit",      16'(digit),            16'h0);
        checkOutput("reset_digit_sel",  16'(digit_sel),        16'h0);
        checkOutput("reset_frame_tick", 16'(frame_tick),       16'h0);
        checkOutput("reset_char_ready", 16'(chars.char_ready), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        modelReset();

        for (int i = 0; i < 12; i++) begin
            dut_xfers = 0;
            for (int c = 0; c < tbl[i].cycles; c++)
                applyStimulus(tbl[i].en, tbl[i].valid, tbl[i].ch);
            checkOutput($sformatf("phase%0d_xfers", i), 16'(dut_xfers), 16'(tbl[i].exp_xfers));
        end

        // Async reset landing in the first DRIVE cycle of digit 2.
        for (int c = 0; c < FP && (k % FP != 2 * DP + BC); c++)
            applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("pre_reset_an", 16'(an), 16'b1011);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_an",         16'(an),               16'hF);
        checkOutput("async_digit",      16'(digit),            16'h0);
        checkOutput("async_digit_sel",  16'(digit_sel),        16'h0);
        checkOutput("async_char_ready", 16'(chars.char_ready), 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        applyStimulus(1'b1, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("an_two_after_release", 16'(an), 16'b1110);
        for (int c = 0; c < FP; c++)
            applyStimulus(1'b1, 1'b1, 4'hC);

        for (int c = 0; c < 800; c++)
            applyStimulus($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
